tl_phase_sched: RTL

//  Timed, demand-actuated phase scheduler for a two-road intersection with protected left turns.

---
 rtl/tl_pkg.sv | 47 ++++
 rtl/tl_dwell_timer.sv | 24 ++
 rtl/tl_phase_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared encodings for the intersection phase scheduler: lamp codes,
// 3-bit state codes and the state-to-lamp decode.
package tl_pkg;

  typedef enum logic [1:0] {
    LAMP_GREEN  = 2'b00,
    LAMP_YELLOW = 2'b01,
    LAMP_LEFT   = 2'b10,
    LAMP_RED    = 2'b11
  } lamp_t;

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    A_LFT  = 3'd2,
    A_LYEL = 3'd3,
    B_GRN  = 3'd4,
    B_YEL  = 3'd5,
    B_LFT  = 3'd6,
    B_LYEL = 3'd7
  } state_t;

  typedef struct packed {
    lamp_t la;
    lamp_t lb;
  } lamps_t;

  // Moore lamp decode; every state keeps at least one road on RED.
  function automatic lamps_t state_lamps(input state_t s);
    lamps_t l;
    l.la = LAMP_RED;
    l.lb = LAMP_RED;
    case (s)
      A_GRN:  l.la = LAMP_GREEN;
      A_YEL:  l.la = LAMP_YELLOW;
      A_LFT:  l.la = LAMP_LEFT;
      A_LYEL: l.la = LAMP_YELLOW;
      B_GRN:  l.lb = LAMP_GREEN;
      B_YEL:  l.lb = LAMP_YELLOW;
      B_LFT:  l.lb = LAMP_LEFT;
      B_LYEL: l.lb = LAMP_YELLOW;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_dwell_timer.sv
// Dwell counter: restarts at 0 when the scheduler changes state and
// otherwise counts up, saturating at all-ones.
module tl_dwell_timer #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  output logic [CW-1:0] dwell
);

  // Count cycles spent in the current state.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      dwell <= '0;
    end else if (clr) begin
      dwell <= '0;
    end else if (dwell != '1) begin
      dwell <= dwell + CW'(1);
    end
  end

endmodule

// File: rtl/tl_phase_sched.sv
// Demand-actuated eight-phase scheduler for a two-road intersection with
// protected left turns and pedestrian walk lamps.
module tl_phase_sched
  import tl_pkg::*;
#(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 32,
  parameter int YELLOW_T  = 3,
  parameter int LEFT_T    = 6,
  parameter int CW        = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       car_a,
  input  logic       car_al,
  input  logic       car_b,
  input  logic       car_bl,
  input  logic       ped_a,
  input  logic       ped_b,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       walk_a,
  output logic       walk_b,
  output logic [2:0] phase
);

  // Last-cycle dwell values: a state of dwell N exits when dwell == N-1.
  localparam logic [CW-1:0] GMIN_END = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_END = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_END  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] LFT_END  = CW'(LEFT_T - 1);

  state_t        state, state_next;
  logic [CW-1:0] dwell;
  logic          al_lat, bl_lat, pa_lat, pb_lat;
  logic          xa, xb;
  logic          state_chg;
  logic          enter_a_grn, enter_b_grn, enter_a_lft, enter_b_lft;
  lamps_t        lamps;

  assign state_chg   = (state_next != state);
  assign enter_a_grn = state_chg && (state_next == A_GRN);
  assign enter_b_grn = state_chg && (state_next == B_GRN);
  assign enter_a_lft = state_chg && (state_next == A_LFT);
  assign enter_b_lft = state_chg && (state_next == B_LFT);

  // Demand for the other road, which is what ends a green.
  assign xa = car_b | bl_lat | pb_lat | al_lat;
  assign xb = car_a | al_lat | pa_lat | bl_lat;

  tl_dwell_timer #(.CW(CW)) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_chg),
    .dwell   (dwell)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= A_GRN;
    else          state <= state_next;
  end

  // Next-state logic: greens rest without cross demand, timed states exit on dwell.
  always_comb begin
    // NOTE: defaults assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      A_GRN:  if (dwell >= GMIN_END && xa && (!car_a || dwell == GMAX_END)) state_next = A_YEL;
      A_YEL:  if (dwell == YEL_END) state_next = al_lat ? A_LFT : B_GRN;
      A_LFT:  if (dwell == LFT_END) state_next = A_LYEL;
      A_LYEL: if (dwell == YEL_END) state_next = B_GRN;
      B_GRN:  if (dwell >= GMIN_END && xb && (!car_b || dwell == GMAX_END)) state_next = B_YEL;
      B_YEL:  if (dwell == YEL_END) state_next = bl_lat ? B_LFT : A_GRN;
      B_LFT:  if (dwell == LFT_END) state_next = B_LYEL;
      B_LYEL: if (dwell == YEL_END) state_next = A_GRN;
      default: state_next = A_GRN;
    endcase
  end

  // Request latches; the clear on serving entry beats a same-cycle request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      al_lat <= 1'b0;
      bl_lat <= 1'b0;
      pa_lat <= 1'b0;
      pb_lat <= 1'b0;
    end else begin
      al_lat <= (al_lat | car_al) & ~enter_a_lft;
      bl_lat <= (bl_lat | car_bl) & ~enter_b_lft;
      pa_lat <= (pa_lat | ped_a)  & ~enter_a_grn;
      pb_lat <= (pb_lat | ped_b)  & ~enter_b_grn;
    end
  end

  // Walk lamps: armed on green entry by a pending request, held for GREEN_MIN cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      walk_a <= 1'b0;
      walk_b <= 1'b0;
    end else begin
      walk_a <= enter_a_grn ? (pa_lat | ped_a)
                            : (walk_a && state_next == A_GRN && dwell != GMIN_END);
      walk_b <= enter_b_grn ? (pb_lat | ped_b)
                            : (walk_b && state_next == B_GRN && dwell != GMIN_END);
    end
  end

  assign lamps = state_lamps(state);
  assign La    = lamps.la;
  assign Lb    = lamps.lb;
  assign phase = state;

endmodule
